// File: rtl/smp_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smp_cache_pkg
//  Description : Shared types, geometry and word helpers for the data cache
//                (4 x 16-bit words per 64-bit line, direct-mapped).
//  Revision    : 1.0 - initial release
// ============================================================================
package smp_cache_pkg;

  localparam int ADDR_W = 13;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 2;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORD_W = 16;
  localparam int LINE_W = 64;
  localparam int LINES  = 1 << IDX_W;
  localparam int MEM_AW = TAG_W + IDX_W;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  // Word 0 lives in the least-significant 16 bits of the line.
  function automatic logic [WORD_W-1:0] word_sel(input line_t line,
                                                 input logic [OFF_W-1:0] off);
    return line[int'(off)*WORD_W +: WORD_W];
  endfunction

  function automatic line_t word_merge(input line_t line,
                                       input logic [OFF_W-1:0] off,
                                       input logic [WORD_W-1:0] word);
    line_t merged;
    merged = line;
    merged[int'(off)*WORD_W +: WORD_W] = word;
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_cache_array.sv
`default_nettype none
// ============================================================================
//  Module      : d_cache_array
//  Description : Tag/valid/dirty/data storage for the direct-mapped cache.
//                Asynchronous read by index; synchronous line fill or word
//                merge. Only valid/dirty are reset - they guard the rest.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_cache_array
  import smp_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output line_t             line_o,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  line_t             fill_line_i,
  input  logic              wr_en_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [WORD_W-1:0] wr_word_i
);

  logic [TAG_W-1:0] tag_q  [LINES];
  line_t            data_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  // Tag and data payload: a fill replaces the whole line, a store merges one word.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[idx_i] <= word_merge(data_q[idx_i], wr_off_i, wr_word_i);
    end
  end

  // Line state: fills arrive clean, stores mark the line dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/d_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : d_cache_ctrl
//  Description : Direct-mapped, write-back, write-allocate data cache
//                controller. Hits complete combinationally; misses stall the
//                CPU while the victim is written back and the line refilled.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_cache_ctrl
  import smp_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rd_data_o,
  output logic              cpu_rdy_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output line_t             mem_wdata_o,
  input  line_t             mem_rd_data_i,
  input  logic              mem_rdy_i
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   cpu_idx;
  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   arr_idx;
  logic [TAG_W-1:0]   arr_tag;
  logic               arr_valid;
  logic               arr_dirty;
  line_t              arr_line;
  logic               req;
  logic               hit;
  logic               wr_en;
  logic               fill_en;

  assign cpu_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_off = cpu_addr_i[OFF_W-1:0];
  // Outside IDLE the array is addressed by the registered miss index so the
  // victim and the refill target stay fixed for the whole transfer.
  assign arr_idx = (state_q == ST_IDLE) ? cpu_idx : miss_idx_q;
  assign req     = cpu_re_i | cpu_we_i;
  assign hit     = arr_valid && (arr_tag == cpu_tag);

  d_cache_array u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (arr_idx),
    .tag_o       (arr_tag),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .line_o      (arr_line),
    .fill_en_i   (fill_en),
    .fill_tag_i  (miss_tag_q),
    .fill_line_i (mem_rd_data_i),
    .wr_en_i     (wr_en),
    .wr_off_i    (cpu_off),
    .wr_word_i   (cpu_wdata_i)
  );

  // Next state, CPU handshake, array write strobes and d_mem request outputs.
  always_comb begin
    state_d       = state_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    cpu_rdy_o     = 1'b0;
    cpu_rd_data_o = '0;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    mem_re_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_rdy_o     = 1'b1;
            cpu_rd_data_o = word_sel(arr_line, cpu_off);
            wr_en         = cpu_we_i;
          end else begin
            miss_idx_d = cpu_idx;
            miss_tag_d = cpu_tag;
            state_d    = (arr_valid && arr_dirty) ? ST_WB_REQ : ST_RD_REQ;
          end
        end
      end
      ST_WB_REQ: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = {arr_tag, miss_idx_q};
        mem_wdata_o = arr_line;
        state_d     = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        mem_addr_o  = {arr_tag, miss_idx_q};
        mem_wdata_o = arr_line;
        if (mem_rdy_i) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q};
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        mem_addr_o = {miss_tag_q, miss_idx_q};
        if (mem_rdy_i) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured miss address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_cache_ctrl
//  Description : Self-checking bench for d_cache_ctrl with a behavioural
//                4-clock d_mem and a word-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rd_data;
  logic        cpu_rdy;
  logic [10:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rd_data;
  logic        mem_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  d_cache_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr_i    (cpu_addr),
    .cpu_re_i      (cpu_re),
    .cpu_we_i      (cpu_we),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rd_data_o (cpu_rd_data),
    .cpu_rdy_o     (cpu_rdy),
    .mem_addr_o    (mem_addr),
    .mem_re_o      (mem_re),
    .mem_we_o      (mem_we),
    .mem_wdata_o   (mem_wdata),
    .mem_rd_data_i (mem_rd_data),
    .mem_rdy_i     (mem_rdy)
  );

  // Power-up content of line L: word0 = {L[6:0],1,L[7:0]}, other words derived.
  function automatic logic [63:0] pattern(input logic [10:0] l);
    logic [15:0] w0;
    w0 = {l[6:0], 1'b1, l[7:0]};
    return {w0 ^ 16'h3C3C, l[7:0], 8'hA5, ~w0, w0};
  endfunction

  // ---------------- d_mem model: request accepted when idle, done 3 clocks later
  logic [63:0]   dmem [2048];
  logic [2047:0] dm_touched;
  logic          dm_init = 1'b1;
  logic [1:0]    dm_cnt;
  logic          dm_wr;
  logic [10:0]   dm_addr;
  logic [63:0]   dm_wdata;
  logic [63:0]   dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_cnt   <= 2'd0;
      dm_wr    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_rdata <= '0;
    end else if (dm_cnt == 2'd0) begin
      if (mem_re || mem_we) begin
        dm_cnt   <= 2'd3;
        dm_wr    <= mem_we;
        dm_addr  <= mem_addr;
        dm_wdata <= mem_wdata;
        dm_rdata <= dm_touched[mem_addr] ? dmem[mem_addr] : pattern(mem_addr);
      end
    end else begin
      dm_cnt <= dm_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (dm_init) begin
      dm_touched <= '0;
    end else if (dm_cnt == 2'd1 && dm_wr) begin
      dmem[dm_addr]       <= dm_wdata;
      dm_touched[dm_addr] <= 1'b1;
    end
  end

  assign mem_rdy     = (dm_cnt == 2'd0) || (dm_cnt == 2'd1);
  assign mem_rd_data = dm_rdata;

  // ---------------- reference model and scoreboard
  logic [15:0] ref_mem [8192];
  logic [15:0] sb_q [$];

  function automatic logic [63:0] ref_line(input logic [10:0] l);
    return {ref_mem[{l, 2'd3}], ref_mem[{l, 2'd2}], ref_mem[{l, 2'd1}], ref_mem[{l, 2'd0}]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [12:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        wb;
    logic [10:0] wb_line;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic re, input logic we, input logic [12:0] addr,
                     input logic [15:0] wdata, input int lat,
                     input logic wb, input logic [10:0] wb_line);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.wb = wb; v.wb_line = wb_line;
    tbl.push_back(v);
  endtask

  // Drives one request (starting just after a posedge) and checks its timing,
  // data and every d_mem transfer it caused.
  task automatic access(input vec_t v, input string tag);
    int          cyc;
    bit          done;
    int          lat;
    int          re_n, we_n, re_cyc, we_cyc;
    logic [10:0] re_a, we_a;
    logic [63:0] we_d, exp_wb;
    logic [15:0] got, exp;
    re_n = 0; we_n = 0; re_cyc = -1; we_cyc = -1;
    re_a = '0; we_a = '0; we_d = '0; got = '0; lat = -1;
    exp_wb = ref_line(v.wb_line);
    if (v.we) ref_mem[v.addr] = v.wdata;
    else if (v.re) sb_q.push_back(ref_mem[v.addr]);
    cpu_addr = v.addr; cpu_re = v.re; cpu_we = v.we; cpu_wdata = v.wdata;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_re) begin re_n++; if (re_cyc < 0) begin re_cyc = cyc; re_a = mem_addr; end end
      if (mem_we) begin we_n++; if (we_cyc < 0) begin we_cyc = cyc; we_a = mem_addr; we_d = mem_wdata; end end
      if (cpu_rdy) begin done = 1; lat = cyc; got = cpu_rd_data; end
      @(posedge clk); #1;
      cyc++;
    end
    cpu_re = 1'b0; cpu_we = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no cpu_rdy within 40 cycles", tag);
      if (v.re && !v.we && sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      chk({tag, " latency"}, 64'(lat), 64'(v.lat));
      if (v.re && !v.we) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s data: scoreboard empty, got %h", tag, got);
        end else begin
          exp = sb_q.pop_front();
          chk({tag, " data"}, 64'(got), 64'(exp));
        end
      end
    end
    chk({tag, " mem_re pulses"}, 64'(re_n), (v.lat > 0) ? 64'd1 : 64'd0);
    chk({tag, " mem_we pulses"}, 64'(we_n), v.wb ? 64'd1 : 64'd0);
    if (v.lat > 0) begin
      chk({tag, " mem_re cycle"}, 64'(re_cyc), v.wb ? 64'd5 : 64'd1);
      chk({tag, " mem_re addr"}, 64'(re_a), 64'(v.addr[12:2]));
    end
    if (v.wb) begin
      chk({tag, " mem_we cycle"}, 64'(we_cyc), 64'd1);
      chk({tag, " mem_we addr"}, 64'(we_a), 64'(v.wb_line));
      chk({tag, " mem_wdata"}, we_d, exp_wb);
    end
  endtask

  initial begin
    logic [15:0] saved;
    vec_t        v;
    for (int a = 0; a < 8192; a++) begin
      logic [63:0] ln;
      ln = pattern(a[12:2]);
      ref_mem[a] = ln[a[1:0]*16 +: 16];
    end

    // Reset state with no request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cpu_rdy", 64'(cpu_rdy), 64'd0);
    chk("reset cpu_rd_data", 64'(cpu_rd_data), 64'd0);
    chk("reset mem_re", 64'(mem_re), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dm_init = 1'b0;
    @(posedge clk); #1;

    //   re  we  addr      wdata     lat wb wb_line
    add(1, 0, 13'h0014, 16'h0000, 5, 0, 11'h000);  // cold load
    add(1, 0, 13'h0014, 16'h0000, 0, 0, 11'h000);  // hit
    add(0, 1, 13'h0015, 16'hBEEF, 0, 0, 11'h000);  // store hit
    add(1, 0, 13'h0015, 16'h0000, 0, 0, 11'h000);
    add(1, 0, 13'h0114, 16'h0000, 9, 1, 11'h005);  // dirty eviction
    add(1, 0, 13'h0015, 16'h0000, 5, 0, 11'h000);  // refetch written-back word
    add(0, 1, 13'h1FFC, 16'h1234, 5, 0, 11'h000);  // store miss, fill then merge
    add(1, 0, 13'h1FFC, 16'h0000, 0, 0, 11'h000);
    add(1, 0, 13'h1FFD, 16'h0000, 0, 0, 11'h000);
    add(1, 0, 13'h0114, 16'h0000, 5, 0, 11'h000);  // clean victim, no writeback
    add(1, 0, 13'h0014, 16'h0000, 5, 0, 11'h000);
    add(1, 0, 13'h00FC, 16'h0000, 9, 1, 11'h7FF);  // dirtied line now written back
    add(1, 0, 13'h1FFC, 16'h0000, 5, 0, 11'h000);
    add(1, 1, 13'h1FFE, 16'h5555, 0, 0, 11'h000);  // load+store acts as store
    add(1, 0, 13'h1FFE, 16'h0000, 0, 0, 11'h000);
    add(1, 0, 13'h0A01, 16'h0000, 5, 0, 11'h000);
    for (int i = 0; i < tbl.size(); i++) access(tbl[i], $sformatf("vec%0d", i));

    // Idle with a hitting address on the bus: no completion, no data.
    cpu_addr = 13'h1FFE;
    @(negedge clk);
    chk("idle cpu_rdy", 64'(cpu_rdy), 64'd0);
    chk("idle cpu_rd_data", 64'(cpu_rd_data), 64'd0);
    @(posedge clk); #1;

    // Dirty line idx 0, then reset during its writeback.
    saved = ref_mem[13'h0A01];
    v.re = 0; v.we = 1; v.addr = 13'h0A01; v.wdata = 16'h7777; v.lat = 0; v.wb = 0; v.wb_line = '0;
    access(v, "dirty idx0");
    cpu_addr = 13'h1A01; cpu_re = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_req mem_we", 64'(mem_we), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid-wb mem_we", 64'(mem_we), 64'd0);
    chk("rst mid-wb mem_re", 64'(mem_re), 64'd0);
    chk("rst mid-wb mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mid-wb mem_wdata", mem_wdata, 64'd0);
    chk("rst mid-wb cpu_rdy", 64'(cpu_rdy), 64'd0);
    cpu_re = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    ref_mem[13'h0A01] = saved;  // the dirty word never reached d_mem

    v.re = 1; v.we = 0; v.addr = 13'h0A01; v.wdata = '0; v.lat = 5; v.wb = 0;
    access(v, "post-rst 0A01");
    v.addr = 13'h0015;
    access(v, "post-rst 0015");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
